stream_mux_rr: RTL and testbench
================================

Name: stream_mux_rr

Overview:
- Parametrised N-to-1 streaming multiplexer with valid/ready handshake on every input and the output.
- Two modes: static select (the classic sel-driven mux) and round-robin arbitration across requesting channels.
- Single registered output stage: 1-cycle latency, full throughput (one transfer per clock).
- Sits between multiple producer channels and one shared consumer; replaces hand-built trees of 2:1 muxes where flow control is needed.

Parameters:
- SEL_W, 2, select/channel-index width; NUM_CH = 2**SEL_W (default 4); legal SEL_W >= 1.
- DATA_W, 8, payload width per channel.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous active-low reset.
- mode  input  1  0 = static select, 1 = round-robin.
- sel  input  SEL_W  channel index used when mode=0; ignored when mode=1.
- in_data  input  NUM_CH*DATA_W  channel i payload at bits [i*DATA_W +: DATA_W].
- in_valid  input  NUM_CH  per-channel valid.
- in_ready  output  NUM_CH  per-channel ready; combinational, at most one bit high.
- out_data  output  DATA_W  registered payload.
- out_ch  output  SEL_W  registered index of the channel out_data came from.
- out_valid  output  1  registered valid.
- out_ready  input  1  consumer ready.

Behaviour:
- Reset (rst_n=0 at posedge): out_valid=0, out_data=0, out_ch=0, internal last_grant=NUM_CH-1 (so ch0 has first RR priority). in_ready is all-zero while out_valid=0 and no input is valid; it is not forced during reset, but no state updates occur in a reset cycle.
- load = !out_valid || out_ready. This is the output-register-can-accept condition.
- Grant, combinational:
  - mode=0: gnt_vld = in_valid[sel], gnt = sel. Other channels are never granted, even if valid.
  - mode=1: gnt is the first i with in_valid[i]=1, searching last_grant+1, last_grant+2, … with modulo-NUM_CH wrap; gnt_vld = |in_valid.
- in_ready[i] = load && gnt_vld && (gnt == i). An input transfer occurs when in_valid[i] && in_ready[i].
- Register update at posedge when load=1:
  - out_valid <= gnt_vld.
  - If gnt_vld: out_data <= channel gnt payload, out_ch <= gnt.
  - If !gnt_vld: out_data and out_ch hold their values.
- When load=0 (out_valid=1, out_ready=0): out_data, out_ch and out_valid all hold. All in_ready=0. Changes on sel, mode or inputs have no effect on the held word.
- last_grant <= gnt only on an accepted transfer in mode=1. In mode=0 last_grant holds.
- Round-robin fairness: with all channels continuously valid and out_ready=1, grant order is 0,1,2,3,0,… One word per cycle, no bubbles.
- Latency: input accepted at edge k appears on out_data/out_valid after edge k (visible in cycle k+1).
- Mode or sel change takes effect on the grant the same cycle, combinationally. A mode switch never drops or duplicates a word.
- Simultaneous output drain and refill: an out_ready=1 handshake and a new input capture happen on the same edge.
- Reset mid-transfer: the held word is discarded and out_valid=0 on the next cycle. RR priority restarts at ch0.
- No combinational path from in_data to out_data. The combinational paths are out_ready → in_ready and in_valid/sel/mode → in_ready.

Test Plan:
- Reset: drive rst_n=0 with in_valid=4'b1111 and out_ready=1 → after the edge, out_valid=0, out_data=0, out_ch=0. The first cycle after release grants ch0.
- Static mode: mode=0, sel=2, in_data={8'h44,8'h33,8'h22,8'h11}, in_valid=4'b0100, out_ready=1 → in_ready=4'b0100; next cycle out_data=8'h33, out_ch=2, out_valid=1. With sel=1 and in_valid=4'b0100 → in_ready=0 and out_valid drops to 0.
- Round-robin: mode=1, in_valid=4'b1111 held, out_ready=1 for 8 cycles → out_ch sequence is 0,1,2,3,0,1,2,3, one word per cycle. With in_valid=4'b1010 → out_ch alternates 1,3.
- Backpressure: out_valid=1 with out_ch=1, then out_ready=0 for 3 cycles while sel/in_data toggle → out_data/out_ch stable and in_ready=0. On out_ready=1 the next grant transfers that edge.
- Mode switch: run RR until last_grant=1, switch to mode=0 with sel=0 for 2 words, then back to mode=1 → the next RR grant is ch2 (last_grant held at 1).
- Reset mid-operation: out_valid=1 and out_ready=0, assert rst_n=0 for one edge → out_valid=0. After release with in_valid=4'b1000, mode=1 → ch3 is granted and out_ch=3.

Source files
------------

// File: rtl/stream_mux_rr.sv
// stream_mux_rr
//   N-to-1 streaming multiplexer. Every input channel and the output use a
//   valid/ready handshake. The channel is chosen either by a static select
//   (mode=0) or by round-robin arbitration across the requesting channels
//   (mode=1). The output is a single register stage, so data has one cycle of
//   latency and the mux can move one word on every clock.
//
// Parameters
//   SEL_W   channel-index width, NUM_CH = 2**SEL_W channels (SEL_W >= 1)
//   DATA_W  payload width per channel
//
// Ports
//   clk        rising-edge clock
//   rst_n      synchronous active-low reset
//   mode       0 = static select, 1 = round-robin
//   sel        channel index used when mode=0
//   in_data    packed payloads, channel i at [i*DATA_W +: DATA_W]
//   in_valid   per-channel valid
//   in_ready   per-channel ready (combinational, one-hot or zero)
//   out_data   registered payload
//   out_ch     registered index of the source channel of out_data
//   out_valid  registered valid
//   out_ready  consumer ready
module stream_mux_rr #(
    parameter int SEL_W  = 2,
    parameter int DATA_W = 8,
    localparam int NUM_CH = 2 ** SEL_W
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     mode,
    input  logic [SEL_W-1:0]         sel,
    input  logic [NUM_CH*DATA_W-1:0] in_data,
    input  logic [NUM_CH-1:0]        in_valid,
    output logic [NUM_CH-1:0]        in_ready,
    output logic [DATA_W-1:0]        out_data,
    output logic [SEL_W-1:0]         out_ch,
    output logic                     out_valid,
    input  logic                     out_ready
);

    // Index of the lowest set bit; zero when the vector is empty.
    function automatic logic [SEL_W-1:0] lowest_set(input logic [NUM_CH-1:0] vec);
        logic [SEL_W-1:0] idx;
        idx = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (vec[i]) begin
                idx = SEL_W'(i);
            end
        end
        return idx;
    endfunction

    // Round-robin pick: prefer requesters strictly above the last grant; if
    // none are left above it, wrap around to the lowest requester overall.
    function automatic logic [SEL_W-1:0] rr_pick(input logic [NUM_CH-1:0] req,
                                                 input logic [SEL_W-1:0]  last);
        logic [NUM_CH-1:0] above;
        for (int i = 0; i < NUM_CH; i++) begin
            above[i] = req[i] && (SEL_W'(i) > last);
        end
        return (|above) ? lowest_set(above) : lowest_set(req);
    endfunction

    logic [DATA_W-1:0] out_data_q,   out_data_d;
    logic [SEL_W-1:0]  out_ch_q,     out_ch_d;
    logic              out_valid_q,  out_valid_d;
    logic [SEL_W-1:0]  last_grant_q, last_grant_d;

    logic              load;
    logic              gnt_vld;
    logic [SEL_W-1:0]  gnt;

    // The output register can take a new word when it is empty or being drained.
    assign load = !out_valid_q || out_ready;

    always_comb begin
        gnt     = '0;
        gnt_vld = 1'b0;
        if (!mode) begin
            gnt     = sel;
            gnt_vld = in_valid[sel];
        end else begin
            gnt     = rr_pick(in_valid, last_grant_q);
            gnt_vld = |in_valid;
        end
    end

    always_comb begin
        in_ready = '0;
        if (load && gnt_vld) begin
            in_ready = NUM_CH'(1) << gnt;
        end
    end

    always_comb begin
        out_data_d   = out_data_q;
        out_ch_d     = out_ch_q;
        out_valid_d  = out_valid_q;
        last_grant_d = last_grant_q;
        if (load) begin
            out_valid_d = gnt_vld;
            if (gnt_vld) begin
                out_data_d = in_data[gnt*DATA_W +: DATA_W];
                out_ch_d   = gnt;
                // Static-select traffic must not disturb round-robin priority.
                if (mode) begin
                    last_grant_d = gnt;
                end
            end
        end
    end

    // Output register stage
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_data_q   <= '0;
            out_ch_q     <= '0;
            out_valid_q  <= 1'b0;
            // Highest index so that channel 0 has first round-robin priority.
            last_grant_q <= SEL_W'(NUM_CH - 1);
        end else begin
            out_data_q   <= out_data_d;
            out_ch_q     <= out_ch_d;
            out_valid_q  <= out_valid_d;
            last_grant_q <= last_grant_d;
        end
    end

    assign out_data  = out_data_q;
    assign out_ch    = out_ch_q;
    assign out_valid = out_valid_q;

endmodule

// File: tb/tb_stream_mux_rr.sv
module tb_stream_mux_rr;

    localparam int SEL_W  = 2;
    localparam int DATA_W = 8;
    localparam int NUM_CH = 4;

    logic                     clk = 1'b0;
    logic                     rst_n = 1'b0;
    logic                     mode = 1'b0;
    logic [SEL_W-1:0]         sel = '0;
    logic [NUM_CH*DATA_W-1:0] in_data = '0;
    logic [NUM_CH-1:0]        in_valid = '0;
    logic [NUM_CH-1:0]        in_ready;
    logic [DATA_W-1:0]        out_data;
    logic [SEL_W-1:0]         out_ch;
    logic                     out_valid;
    logic                     out_ready = 1'b0;

    stream_mux_rr #(.SEL_W(SEL_W), .DATA_W(DATA_W)) dut (
        .clk(clk), .rst_n(rst_n), .mode(mode), .sel(sel),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .out_data(out_data), .out_ch(out_ch), .out_valid(out_valid),
        .out_ready(out_ready)
    );

    always #5 clk = ~clk;

    int n_vec  = 0;
    int n_fail = 0;

    // Reference model state
    logic [9:0] exp_q[$];     // {channel, payload} in delivery order
    int         seen_ch[$];   // channels delivered to the consumer
    bit         m_known = 0;
    bit         m_ovalid = 0;
    int         m_last = NUM_CH - 1;

    // Snapshots taken during the most recent call to cycle()
    logic             snap_valid;
    logic [7:0]       snap_data;
    logic [1:0]       snap_ch;
    logic [3:0]       snap_rdy;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Which channel should be served, straight from the arbitration rules.
    function automatic int ref_grant(input logic m, input int s, input logic [3:0] v,
                                     input int last, output bit gv);
        if (!m) begin
            gv = v[s];
            return s;
        end
        gv = 0;
        for (int k = 1; k <= NUM_CH; k++) begin
            int c;
            c = (last + k) % NUM_CH;
            if (v[c]) begin
                gv = 1;
                return c;
            end
        end
        return 0;
    endfunction

    // One clock: snapshot outputs after the edge, drive inputs, then predict
    // what the coming edge does.
    task automatic cycle(input logic r, input logic m, input logic [1:0] s,
                         input logic [3:0] v, input logic [31:0] d, input logic o);
        bit gv;
        int g;
        bit ld;
        logic [3:0] exp_rdy;
        @(posedge clk);
        #1;
        snap_valid = out_valid;
        snap_data  = out_data;
        snap_ch    = out_ch;
        if (m_known) chk("out_valid", {31'd0, out_valid}, {31'd0, m_ovalid});
        rst_n = r; mode = m; sel = s; in_valid = v; in_data = d; out_ready = o;
        #3;
        snap_rdy = in_ready;
        if (!r) begin
            exp_q.delete();
            m_ovalid = 0;
            m_last   = NUM_CH - 1;
            m_known  = 1;
        end else if (m_known) begin
            g  = ref_grant(m, int'(s), v, m_last, gv);
            ld = !m_ovalid || o;
            exp_rdy = (ld && gv) ? (4'b0001 << g) : 4'b0000;
            chk("in_ready", {28'd0, in_ready}, {28'd0, exp_rdy});
            if (ld) begin
                m_ovalid = gv;
                if (gv) begin
                    exp_q.push_back({g[1:0], d[g*8 +: 8]});
                    if (m) m_last = g;
                end
            end
        end
    endtask

    // Monitor: whatever sits in the output register must be the oldest
    // outstanding word; it retires on an output handshake.
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n && m_known && out_valid) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_out", {22'd0, out_ch, out_data}, 32'hFFFF_FFFF);
                end else begin
                    chk("out_word", {22'd0, out_ch, out_data}, {22'd0, exp_q[0]});
                    if (out_ready) begin
                        void'(exp_q.pop_front());
                        seen_ch.push_back(int'(out_ch));
                    end
                end
            end
        end
    end

    initial begin
        int rr_exp[12];
        rr_exp = '{0, 1, 2, 3, 0, 1, 2, 3, 1, 3, 1, 3};

        // Reset with every channel requesting and the consumer ready
        cycle(0, 1, 0, 4'b1111, 32'h44332211, 1);
        cycle(1, 1, 0, 4'b1111, 32'h44332211, 1);
        chk("rst_valid", {31'd0, snap_valid}, 0);
        chk("rst_data",  {24'd0, snap_data}, 0);
        chk("rst_ch",    {30'd0, snap_ch}, 0);
        chk("rst_first_grant", {28'd0, snap_rdy}, 32'b0001);

        // Static select
        cycle(1, 0, 2, 4'b0100, 32'h44332211, 1);
        chk("static_rdy", {28'd0, snap_rdy}, 32'b0100);
        cycle(1, 0, 1, 4'b0100, 32'h44332211, 1);
        chk("static_data", {24'd0, snap_data}, 32'h33);
        chk("static_ch",   {30'd0, snap_ch}, 2);
        chk("static_vld",  {31'd0, snap_valid}, 1);
        chk("static_other_rdy", {28'd0, snap_rdy}, 0);
        cycle(1, 0, 1, 4'b0000, 32'h44332211, 1);
        chk("static_drop", {31'd0, snap_valid}, 0);

        // Round-robin ordering
        cycle(0, 1, 0, 4'b0000, 32'h0, 1);
        seen_ch.delete();
        for (int i = 0; i < 8; i++) cycle(1, 1, 0, 4'b1111, $urandom, 1);
        for (int i = 0; i < 4; i++) cycle(1, 1, 0, 4'b1010, $urandom, 1);
        for (int i = 0; i < 3; i++) cycle(1, 1, 0, 4'b0000, $urandom, 1);
        chk("rr_count", seen_ch.size(), 12);
        for (int i = 0; i < 12 && i < seen_ch.size(); i++) chk("rr_order", seen_ch[i], rr_exp[i]);

        // Backpressure holds the word and blocks all inputs
        cycle(1, 0, 1, 4'b0010, 32'hA0B0C0D0, 1);
        for (int i = 0; i < 3; i++) begin
            cycle(1, 0, 2'(i), 4'b1111, $urandom, 0);
            chk("bp_ch",  {30'd0, snap_ch}, 1);
            chk("bp_data", {24'd0, snap_data}, 32'hC0);
            chk("bp_rdy", {28'd0, snap_rdy}, 0);
        end
        cycle(1, 0, 2, 4'b1111, $urandom, 1);
        chk("bp_release_rdy", {28'd0, snap_rdy}, 32'b0100);

        // Static traffic leaves round-robin priority untouched
        cycle(0, 1, 0, 4'b0000, 32'h0, 1);
        cycle(1, 1, 0, 4'b1111, $urandom, 1);
        cycle(1, 1, 0, 4'b1111, $urandom, 1);
        cycle(1, 0, 0, 4'b1111, $urandom, 1);
        cycle(1, 0, 0, 4'b1111, $urandom, 1);
        cycle(1, 1, 0, 4'b1111, $urandom, 1);
        chk("mode_switch_rr", {28'd0, snap_rdy}, 32'b0100);

        // Reset while a word is stalled in the output register
        cycle(1, 0, 0, 4'b0001, 32'h000000E1, 1);
        cycle(1, 0, 0, 4'b0000, 32'h0, 0);
        cycle(0, 0, 0, 4'b0000, 32'h0, 0);
        cycle(1, 1, 0, 4'b1000, 32'h7F000000, 1);
        chk("midrst_valid", {31'd0, snap_valid}, 0);
        chk("midrst_rdy", {28'd0, snap_rdy}, 32'b1000);
        cycle(1, 1, 0, 4'b0000, 32'h0, 1);
        chk("midrst_ch", {30'd0, snap_ch}, 3);
        chk("midrst_data", {24'd0, snap_data}, 32'h7F);

        // Randomised traffic
        for (int i = 0; i < 3000; i++) begin
            cycle(($urandom_range(0, 99) != 0), $urandom_range(0, 1), 2'($urandom),
                  4'($urandom), $urandom, ($urandom_range(0, 3) != 0));
        end
        for (int i = 0; i < 4; i++) cycle(1, 1, 0, 4'b0000, 32'h0, 1);
        chk("drained", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
